// File: rtl/key_click_decoder.sv
// Groups debounced key-press strobes into click sequences closed by an
// inactivity window or by reaching MAX_CLICKS; emits a one-cycle strobe plus count.
module key_click_decoder #(
  parameter int WINDOW_CYCLES = 8,
  parameter int MAX_CLICKS    = 3,
  parameter int CNT_W         = $clog2(MAX_CLICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_pressed_stb_i,
  output logic             click_valid_o,
  output logic [CNT_W-1:0] click_cnt_o,
  output logic             busy_o
);

  localparam int TMR_W = $clog2(WINDOW_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CLICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CLICKS);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(WINDOW_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [TMR_W-1:0]   timer_r, timer_nxt_s;
  logic               emit_s;
  logic [CNT_W-1:0]   emit_cnt_s;
  logic               click_valid_r;
  logic [CNT_W-1:0]   click_cnt_r;

  // State, click counter and silence timer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      timer_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Next-state logic; a strobe always takes priority over a timeout
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    timer_nxt_s = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (key_pressed_stb_i) begin
          state_nxt_s = ST_COUNT;
          cnt_nxt_s   = CNT_W'(1);
          timer_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (key_pressed_stb_i) begin
          timer_nxt_s = '0;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end else if (timer_r == TMR_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          timer_nxt_s = '0;
        end else begin
          timer_nxt_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
        timer_nxt_s = '0;
      end
    endcase
  end

  // Emit decision: sequence closes on the last allowed click or on timeout
  always_comb begin
    emit_s     = 1'b0;
    emit_cnt_s = click_cnt_r;
    case (state_r)
      ST_IDLE: begin
        emit_s = 1'b0;
      end
      ST_COUNT: begin
        if (key_pressed_stb_i && (cnt_r == CNT_LAST)) begin
          emit_s     = 1'b1;
          emit_cnt_s = CNT_MAX;
        end else if (!key_pressed_stb_i && (timer_r == TMR_LAST)) begin
          emit_s     = 1'b1;
          emit_cnt_s = cnt_r;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: begin
        emit_s = 1'b0;
      end
    endcase
  end

  // Registered result strobe; the count holds between strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      click_valid_r <= 1'b0;
      click_cnt_r   <= '0;
    end else begin
      click_valid_r <= emit_s;
      click_cnt_r   <= emit_cnt_s;
    end
  end

  assign click_valid_o = click_valid_r;
  assign click_cnt_o   = click_cnt_r;
  assign busy_o        = (state_r == ST_COUNT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench: directed latency scenarios plus random strobes/resets,
// compared every cycle against a timestamp-based reference model.
module tb_key_click_decoder;

  localparam int WIN   = 8;
  localparam int MAXC  = 3;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             key_pressed_stb_i;
  logic             click_valid_o;
  logic [CNT_W-1:0] click_cnt_o;
  logic             busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_valid_cyc = -1;
  int valid_seen     = 0;

  // Reference model state: open sequence, its size and the cycle of the last press
  bit m_open    = 1'b0;
  int m_count   = 0;
  int m_last    = 0;
  bit m_valid   = 1'b0;
  int m_cnt_out = 0;

  key_click_decoder #(
    .WINDOW_CYCLES(WIN),
    .MAX_CLICKS   (MAXC)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .key_pressed_stb_i(key_pressed_stb_i),
    .click_valid_o    (click_valid_o),
    .click_cnt_o      (click_cnt_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs after the edge that samples cycle n's inputs
  task automatic model_update(input bit stb, input bit rst, input int n);
    m_valid = 1'b0;
    if (rst) begin
      m_open    = 1'b0;
      m_count   = 0;
      m_cnt_out = 0;
    end else if (stb) begin
      if (!m_open) begin
        m_open  = 1'b1;
        m_count = 0;
      end
      m_count++;
      m_last = n;
      if (m_count == MAXC) begin
        m_valid   = 1'b1;
        m_cnt_out = m_count;
        m_open    = 1'b0;
      end
    end else if (m_open && (n - m_last == WIN)) begin
      m_valid   = 1'b1;
      m_cnt_out = m_count;
      m_open    = 1'b0;
    end
  endtask

  task automatic step(input bit stb, input bit rst);
    key_pressed_stb_i = stb;
    rst_i             = rst;
    @(posedge clk_i);
    model_update(stb, rst, cyc);
    cyc++;
    #1;
    if (click_valid_o === 1'b1) begin
      last_valid_cyc = cyc;
      valid_seen++;
    end
    chk("valid", int'(click_valid_o), int'(m_valid));
    chk("cnt",   int'(click_cnt_o),   m_cnt_out);
    chk("busy",  int'(busy_o),        int'(m_open));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  int base;
  int seen0;

  initial begin
    key_pressed_stb_i = 1'b0;
    rst_i             = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_valid", int'(click_valid_o), 0);
    chk("rst_cnt",   int'(click_cnt_o),   0);
    chk("rst_busy",  int'(busy_o),        0);
    idle(3);

    // Single press: valid at +9, count 1
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(12);
    chk("single_lat", last_valid_cyc - base, 9);
    chk("single_num", valid_seen - seen0, 1);

    // Double press at 0 and 5: valid at 14
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(4); step(1'b1, 1'b0); idle(12);
    chk("double_lat", last_valid_cyc - base, 14);
    chk("double_num", valid_seen - seen0, 1);

    // Max clicks at 0, 2, 4: valid at 5
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(12);
    chk("max_lat", last_valid_cyc - base, 5);
    chk("max_num", valid_seen - seen0, 1);

    // Consecutive strobes at 0, 1, 2: valid at 3
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); idle(12);
    chk("burst_lat", last_valid_cyc - base, 3);
    chk("burst_num", valid_seen - seen0, 1);

    // Strobe colliding with timeout at 8: valid at 17 with count 2
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(7); step(1'b1, 1'b0); idle(12);
    chk("coll_lat", last_valid_cyc - base, 17);
    chk("coll_num", valid_seen - seen0, 1);

    // Reset mid-sequence at 3, fresh strobe at 10: only valid at 19
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1); idle(6); step(1'b1, 1'b0); idle(12);
    chk("rstmid_lat", last_valid_cyc - base, 19);
    chk("rstmid_num", valid_seen - seen0, 1);

    // Back-to-back: strobe at 0, another in the emit cycle 9
    base = cyc; seen0 = valid_seen;
    step(1'b1, 1'b0); idle(8); step(1'b1, 1'b0); idle(12);
    chk("b2b_lat", last_valid_cyc - base, 18);
    chk("b2b_num", valid_seen - seen0, 2);

    // Random strobes with varying density and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(1, 12);
      for (int i = 0; i < 150; i++) begin
        bit s;
        bit r;
        s = ($urandom_range(0, dens) == 0);
        r = ($urandom_range(0, 199) == 0);
        step(s, r);
      end
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Downstream consumer of the debounce stage's `key_pressed_stb_o`. It groups debounced key-press strobes into click sequences (single, double, triple, ...) separated by an inactivity window. For each completed sequence it emits a one-cycle valid strobe together with the click count. The strobe feeds the mode/command logic of the lab design.

## Interface

Parameters:
- `WINDOW_CYCLES`, default 8: number of silent cycles after a press that closes a sequence. Legal range is ≥ 2.
- `MAX_CLICKS`, default 3: click count at which a sequence closes immediately. Legal range is 2..15.
- `CNT_W`, default `$clog2(MAX_CLICKS+1)`: derived; width of the click count. Do not override.

Ports:
- `clk_i` input 1: single clock; all logic is on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `key_pressed_stb_i` input 1: one-cycle press strobe from debounce, synchronous to `clk_i`.
- `click_valid_o` output 1: one-cycle strobe marking a completed sequence.
- `click_cnt_o` output `CNT_W`: click count of the last completed sequence. Holds its value between strobes.
- `busy_o` output 1: high while a sequence is open (state COUNT).

## Operation

- FSM states:
  - IDLE: no sequence open.
  - COUNT: sequence open.
- Internal registers:
  - `cnt` (`CNT_W` bits): clicks in the open sequence.
  - `timer` (`$clog2(WINDOW_CYCLES)` bits): silent cycles since the last press.
- In IDLE, strobe sampled: go to COUNT, `cnt`<=1, `timer`<=0.
- In IDLE, no strobe: stay in IDLE, registers hold.
- In COUNT, strobe sampled with `cnt` < `MAX_CLICKS`-1: `cnt`<=`cnt`+1, `timer`<=0, stay in COUNT.
- In COUNT, strobe sampled with `cnt` == `MAX_CLICKS`-1: emit `MAX_CLICKS`, go to IDLE, `cnt`<=0.
- In COUNT, no strobe and `timer` < `WINDOW_CYCLES`-1: `timer`<=`timer`+1.
- In COUNT, no strobe and `timer` == `WINDOW_CYCLES`-1 (timeout): emit `cnt`, go to IDLE, `cnt`<=0, `timer`<=0.
- Emit means, at the same edge: `click_valid_o`<=1 and `click_cnt_o`<=emitted value. `click_valid_o` drops on the next edge unless another emit occurs there.
- A strobe and a timeout in the same cycle: the strobe wins. The press is counted and the timer restarts; there is no emit.
- A strobe in the cycle `click_valid_o` is high: the FSM is already in IDLE, so the strobe opens a new sequence. No press is ever lost.
- `cnt` never exceeds `MAX_CLICKS`, so there is no wrap-around. `timer` saturates at `WINDOW_CYCLES`-1 because it resets on leaving COUNT.
- Reset mid-sequence: the open sequence is discarded with no emit. All state returns to the reset values below.

## Timing

- Reset values: state IDLE, `cnt`=0, `timer`=0, `click_valid_o`=0, `click_cnt_o`=0, `busy_o`=0.
- All outputs are registered; no combinational path from input to output.
- `busy_o` rises one cycle after the opening strobe and falls in the same cycle `click_valid_o` rises.
- Timeout latency: `click_valid_o` is high exactly `WINDOW_CYCLES`+1 cycles after the cycle of the last strobe.
- Max-click latency: `click_valid_o` is high exactly 1 cycle after the `MAX_CLICKS`-th strobe.
- Throughput: strobes in consecutive cycles are all counted. A new sequence may start in the emit cycle.

## Test plan

All scenarios use `WINDOW_CYCLES`=8 and `MAX_CLICKS`=3. Cycle numbers are relative to the first strobe at cycle 0.

- Single press: strobe at 0 -> `click_valid_o` high only at cycle 9, `click_cnt_o`=1. `busy_o` is high on cycles 1..8.
- Double press: strobes at 0 and 5 -> valid at 14 with count 2. No valid before cycle 14.
- Max clicks: strobes at 0, 2, 4 -> valid at 5 with count 3, `busy_o`=0 at 5. Consecutive strobes at 0, 1, 2 -> valid at 3 with count 3.
- Strobe vs timeout collision: strobes at 0 and 8 (`timer`=7 at cycle 8) -> no valid at 9; valid at 17 with count 2.
- Reset mid-sequence: strobe at 0, `rst_i` high at cycle 3 -> no valid ever, `busy_o`=0 from cycle 4. Then a strobe at 10 -> valid at 19 with count 1.
- Back-to-back sequences: strobe at 0 -> valid at 9 (count 1). A strobe at 9 -> valid at 18 with count 1. `click_cnt_o` holds 1 on cycles 10..17.
